// File: rtl/cart_header_probe_if.sv
// cart_header_probe_if: ioctl download beat bundle with wait/ack pacing.
// Ports: ioctl_wr/addr/dout and dn_ack from master, ioctl_wait from slave.
interface cart_header_probe_if #(
   parameter int DW     = 16,
   parameter int ADDR_W = 25
);
   logic              ioctl_wr;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [DW-1:0]     ioctl_dout;
   logic              ioctl_wait;
   logic              dn_ack;

   modport master (
      output ioctl_wr,
      output ioctl_addr,
      output ioctl_dout,
      output dn_ack,
      input  ioctl_wait
   );

   modport slave (
      input  ioctl_wr,
      input  ioctl_addr,
      input  ioctl_dout,
      input  dn_ack,
      output ioctl_wait
   );
endinterface

// File: rtl/cart_header_probe.sv
// cart_header_probe: GB header parse, checksum, wait/ack pacing, logo probes.
// Ports: clk_sys, reset_n, cart_download, io (slave beat bus), header
// fields, hdr_done, hdr_valid, probe_match, sachen.
// Macro CART_SACHEN_DETECT_EN enables Sachen detection at byte 0x150.
module cart_header_probe #(
   parameter int DW           = 16,
   parameter int ADDR_W       = 25,
   parameter int NPROBE       = 4,
   parameter int PROBE_STRIDE = 'h40000
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               cart_download,
   cart_header_probe_if.slave io,
   output logic [7:0]         mbc_type,
   output logic [7:0]         rom_size,
   output logic [7:0]         ram_size,
   output logic               cgb_flag,
   output logic [7:0]         sgb_flag,
   output logic [7:0]         old_licensee,
   output logic               hdr_done,
   output logic               hdr_valid,
   output logic [NPROBE-1:0]  probe_match,
   output logic               sachen
);

   localparam int NB = DW / 8;

`ifdef CART_SACHEN_DETECT_EN
   localparam logic [11:0] HDR_LAST = 12'h150;
`else
   localparam logic [11:0] HDR_LAST = 12'h14F;
`endif

   typedef enum logic [1:0] {IDLE, HEADER, STREAM, DONE} state_t;

   state_t      st;
   logic        dl_q;
   logic        wait_q;
   logic [7:0]  x_q;
   logic [7:0]  logo [16];
   logic [15:0] seen [NPROBE];
   logic [15:0] eq   [NPROBE];

`ifdef CART_SACHEN_DETECT_EN
   logic        sachen_q;
   logic        t1_q;
   logic        t2_q;
   assign sachen = sachen_q;
`else
   assign sachen = 1'b0;
`endif

   logic rise, fall, acc, parse, bank0;

   assign rise  = cart_download & ~dl_q;
   assign fall  = ~cart_download & dl_q;
   assign acc   = io.ioctl_wr & ~wait_q;
   assign parse = acc & cart_download & dl_q &
                  ((st == HEADER) | (st == STREAM));
   assign bank0 = (io.ioctl_addr[ADDR_W-1:12] == '0);
   assign io.ioctl_wait = wait_q;

   logic [7:0]        lb [NB];
   logic [ADDR_W-1:0] la [NB];
   logic [7:0]        x_n;
   logic              cmp_hit;
   logic              cmp_ok;
   logic              last_hit;
   logic [15:0]       lg_we;
   logic [7:0]        lg_d [16];
   logic [15:0]       p_hit [NPROBE];
   logic [15:0]       p_eq  [NPROBE];

   // Lanes are walked in address order so a beat holding both 0x14C
   // and 0x14D compares against the sum that already includes 0x14C.
   always_comb begin : decode
      logic [ADDR_W-1:0] d;
      d        = '0;
      x_n      = x_q;
      cmp_hit  = 1'b0;
      cmp_ok   = 1'b0;
      last_hit = 1'b0;
      lg_we    = '0;
      for (int j = 0; j < 16; j++) lg_d[j] = 8'h00;
      for (int k = 0; k < NPROBE; k++) begin
         p_hit[k] = '0;
         p_eq[k]  = '0;
      end
      for (int i = 0; i < NB; i++) begin
         lb[i] = io.ioctl_dout[8*i +: 8];
         la[i] = io.ioctl_addr + ADDR_W'(i);
      end
      for (int i = 0; i < NB; i++) begin
         if (bank0) begin
            if (la[i][11:0] >= 12'h134 &&
                la[i][11:0] <= 12'h14C)
               x_n = x_n - lb[i] - 8'd1;
            if (la[i][11:0] == 12'h14D) begin
               cmp_hit = 1'b1;
               cmp_ok  = (lb[i] == x_n);
            end
            if (la[i][11:0] == HDR_LAST)
               last_hit = 1'b1;
            d = la[i] - ADDR_W'('h104);
            if (d < ADDR_W'(16)) begin
               lg_we[d[3:0]] = 1'b1;
               lg_d[d[3:0]]  = lb[i];
            end
         end
         for (int k = 0; k < NPROBE; k++) begin
            d = la[i] - ADDR_W'((k + 1) * PROBE_STRIDE)
                      - ADDR_W'('h104);
            if (d < ADDR_W'(16)) begin
               p_hit[k][d[3:0]] = 1'b1;
               p_eq[k][d[3:0]]  = (lb[i] == logo[d[3:0]]);
            end
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         st           <= IDLE;
         dl_q         <= 1'b0;
         wait_q       <= 1'b0;
         x_q          <= 8'h00;
         mbc_type     <= 8'h00;
         rom_size     <= 8'h00;
         ram_size     <= 8'h00;
         cgb_flag     <= 1'b0;
         sgb_flag     <= 8'h00;
         old_licensee <= 8'h00;
         hdr_done     <= 1'b0;
         hdr_valid    <= 1'b0;
         probe_match  <= '0;
         for (int j = 0; j < 16; j++) logo[j] <= 8'h00;
         for (int k = 0; k < NPROBE; k++) begin
            seen[k] <= '0;
            eq[k]   <= '0;
         end
`ifdef CART_SACHEN_DETECT_EN
         sachen_q <= 1'b0;
         t1_q     <= 1'b0;
         t2_q     <= 1'b0;
`endif
      end else begin
         dl_q <= cart_download;
         if (acc)
            wait_q <= 1'b1;
         else if (io.dn_ack)
            wait_q <= 1'b0;

         if (rise) begin
            st           <= HEADER;
            x_q          <= 8'h00;
            mbc_type     <= 8'h00;
            rom_size     <= 8'h00;
            ram_size     <= 8'h00;
            cgb_flag     <= 1'b0;
            sgb_flag     <= 8'h00;
            old_licensee <= 8'h00;
            hdr_done     <= 1'b0;
            hdr_valid    <= 1'b0;
            probe_match  <= '0;
            for (int k = 0; k < NPROBE; k++) begin
               seen[k] <= '0;
               eq[k]   <= '0;
            end
`ifdef CART_SACHEN_DETECT_EN
            sachen_q <= 1'b0;
            t1_q     <= 1'b0;
            t2_q     <= 1'b0;
`endif
         end else begin
            unique case (st)
               IDLE, DONE: ;
               HEADER, STREAM: begin
                  if (fall) begin
                     st       <= DONE;
                     hdr_done <= 1'b1;
                     if (st == HEADER)
                        hdr_valid <= 1'b0;
                     for (int k = 0; k < NPROBE; k++)
                        probe_match[k] <= (st == STREAM) &
                                          (&seen[k]) & (&eq[k]);
                  end else if (parse) begin
                     x_q <= x_n;
                     if (cmp_hit)
                        hdr_valid <= cmp_ok;
                     for (int j = 0; j < 16; j++)
                        if (lg_we[j]) logo[j] <= lg_d[j];
                     for (int k = 0; k < NPROBE; k++) begin
                        seen[k] <= seen[k] | p_hit[k];
                        eq[k]   <= (eq[k] & ~p_hit[k]) | p_eq[k];
                     end
                     for (int i = 0; i < NB; i++) begin
                        if (bank0) begin
                           case (la[i][11:0])
                              12'h143: cgb_flag     <= lb[i][7];
                              12'h146: sgb_flag     <= lb[i];
                              12'h147: mbc_type     <= lb[i];
                              12'h148: rom_size     <= lb[i];
                              12'h149: ram_size     <= lb[i];
                              12'h14B: old_licensee <= lb[i];
`ifdef CART_SACHEN_DETECT_EN
                              12'h101: t1_q <= (lb[i] != 8'hC3);
                              12'h140: t2_q <= (lb[i] == 8'hC3);
`endif
                              default: ;
                           endcase
                        end
                     end
                     if (st == HEADER && last_hit)
                        st <= STREAM;
`ifdef CART_SACHEN_DETECT_EN
                     if (st == HEADER && last_hit && t1_q && t2_q) begin
                        sachen_q     <= 1'b1;
                        mbc_type     <= 8'h00;
                        rom_size     <= 8'h00;
                        ram_size     <= 8'h00;
                        sgb_flag     <= 8'h00;
                        old_licensee <= 8'h00;
                        hdr_valid    <= 1'b1;
                     end
`endif
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cart_header_probe.sv
// tb_cart_header_probe: scoreboard bench for cart_header_probe.
// Drives sparse download images; checks header, checksum, probes, pacing.
module tb_cart_header_probe;

   localparam int DW     = 16;
   localparam int AW     = 25;
   localparam int NP     = 4;
   localparam int STRIDE = 'h40000;
`ifdef CART_SACHEN_DETECT_EN
   localparam int LASTB  = 'h150;
`else
   localparam int LASTB  = 'h14F;
`endif

   logic          clk_sys       = 1'b0;
   logic          reset_n       = 1'b0;
   logic          cart_download = 1'b0;
   logic [7:0]    mbc_type;
   logic [7:0]    rom_size;
   logic [7:0]    ram_size;
   logic          cgb_flag;
   logic [7:0]    sgb_flag;
   logic [7:0]    old_licensee;
   logic          hdr_done;
   logic          hdr_valid;
   logic [NP-1:0] probe_match;
   logic          sachen;

   always #5 clk_sys = ~clk_sys;

   cart_header_probe_if #(.DW(DW), .ADDR_W(AW)) io ();

   cart_header_probe #(
      .DW(DW), .ADDR_W(AW), .NPROBE(NP), .PROBE_STRIDE(STRIDE)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .cart_download(cart_download),
      .io           (io),
      .mbc_type     (mbc_type),
      .rom_size     (rom_size),
      .ram_size     (ram_size),
      .cgb_flag     (cgb_flag),
      .sgb_flag     (sgb_flag),
      .old_licensee (old_licensee),
      .hdr_done     (hdr_done),
      .hdr_valid    (hdr_valid),
      .probe_match  (probe_match),
      .sachen       (sachen)
   );

   typedef struct packed {
      logic [7:0]    mbc;
      logic [7:0]    rom;
      logic [7:0]    ram;
      logic          cgb;
      logic [7:0]    sgb;
      logic [7:0]    lic;
      logic          valid;
      logic [NP-1:0] pm;
      logic          sach;
   } exp_t;

   exp_t       sb [$];
   exp_t       mon_e;
   logic [7:0] img [int];
   int         n_chk    = 0;
   int         n_err    = 0;
   int         wait_cnt = 0;
   int         beats    = 0;
   bit         glitch_en = 1'b0;
   logic       done_q   = 1'b0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({mbc_type, rom_size, ram_size, sgb_flag, old_licensee,
                  cgb_flag, hdr_done, hdr_valid, probe_match, sachen,
                  io.ioctl_wait});
   endfunction

   function automatic logic [7:0] byte_at(input int a);
      logic [31:0] u;
      u = a;
      if (img.exists(a)) return img[a];
      return u[7:0] ^ u[15:8] ^ {u[19:16], u[23:20]} ^ 8'h5A;
   endfunction

   function automatic logic [7:0] hdr_chk();
      logic [7:0] x;
      x = 8'h00;
      for (int a = 'h134; a <= 'h14C; a++) x = x - byte_at(a) - 8'd1;
      return x;
   endfunction

   function automatic exp_t model(input int hend, input logic [NP-1:0] win);
      exp_t       e;
      logic [7:0] b;
      logic       ok;
      int         base;
      e = '0;
      e.mbc = (hend > 'h147) ? byte_at('h147) : 8'h00;
      e.rom = (hend > 'h148) ? byte_at('h148) : 8'h00;
      e.ram = (hend > 'h149) ? byte_at('h149) : 8'h00;
      e.sgb = (hend > 'h146) ? byte_at('h146) : 8'h00;
      e.lic = (hend > 'h14B) ? byte_at('h14B) : 8'h00;
      b = byte_at('h143);
      e.cgb = (hend > 'h143) ? b[7] : 1'b0;
      if (hend > LASTB) begin
         e.valid = (byte_at('h14D) == hdr_chk());
         for (int k = 0; k < NP; k++) begin
            base = (k + 1) * STRIDE;
            ok = win[k] && (hend > 'h113);
            for (int j = 0; j < 16; j++)
               if (byte_at(base + 'h104 + j) != byte_at('h104 + j))
                  ok = 1'b0;
            e.pm[k] = ok;
         end
      end
`ifdef CART_SACHEN_DETECT_EN
      if (hend > 'h150 && byte_at('h101) != 8'hC3 &&
          byte_at('h140) == 8'hC3) begin
         e.sach  = 1'b1;
         e.mbc   = 8'h00;
         e.rom   = 8'h00;
         e.ram   = 8'h00;
         e.sgb   = 8'h00;
         e.lic   = 8'h00;
         e.valid = 1'b1;
      end
`endif
      return e;
   endfunction

   always @(negedge clk_sys) begin
      if (io.ioctl_wait) wait_cnt++;
      if (hdr_done && !done_q) begin
         if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("mbc_type", 64'(mbc_type), 64'(mon_e.mbc));
            check("rom_size", 64'(rom_size), 64'(mon_e.rom));
            check("ram_size", 64'(ram_size), 64'(mon_e.ram));
            check("cgb_flag", 64'(cgb_flag), 64'(mon_e.cgb));
            check("sgb_flag", 64'(sgb_flag), 64'(mon_e.sgb));
            check("old_lic", 64'(old_licensee), 64'(mon_e.lic));
            check("hdr_valid", 64'(hdr_valid), 64'(mon_e.valid));
            check("probe_match", 64'(probe_match), 64'(mon_e.pm));
            check("sachen", 64'(sachen), 64'(mon_e.sach));
         end
      end
      done_q = hdr_done;
   end

   // One beat: wr for a cycle, 3 idle cycles, then dn_ack for a cycle.
   task automatic send_beat(input int a);
      io.ioctl_addr = AW'(a);
      io.ioctl_dout = {byte_at(a + 1), byte_at(a)};
      io.ioctl_wr   = 1'b1;
      beats++;
      @(posedge clk_sys); #1;
      io.ioctl_wr = 1'b0;
      @(posedge clk_sys); #1;
      if (glitch_en && a == 'h146) begin
         io.ioctl_dout = ~{byte_at(a + 1), byte_at(a)};
         io.ioctl_wr   = 1'b1;
      end
      @(posedge clk_sys); #1;
      io.ioctl_wr = 1'b0;
      @(posedge clk_sys); #1;
      io.dn_ack = 1'b1;
      @(posedge clk_sys); #1;
      io.dn_ack = 1'b0;
   endtask

   task automatic stream(input int lo, input int hi);
      for (int a = lo; a < hi; a += 2) send_beat(a);
   endtask

   task automatic start_dl();
      @(posedge clk_sys); #1;
      cart_download = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
   endtask

   task automatic end_dl();
      @(posedge clk_sys); #1;
      cart_download = 1'b0;
      @(negedge clk_sys);
      check("done_early", 64'(hdr_done), 64'd0);
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("done_lat", 64'(hdr_done), 64'd1);
      repeat (2) @(posedge clk_sys);
      #1;
   endtask

   task automatic download(input int hend, input logic [NP-1:0] win);
      int w0, b0;
      sb.push_back(model(hend, win));
      start_dl();
      w0 = wait_cnt;
      b0 = beats;
      stream(0, hend);
      for (int k = 0; k < NP; k++)
         if (win[k])
            stream((k + 1) * STRIDE + 'h104, (k + 1) * STRIDE + 'h114);
      check("wait_cycles", 64'(wait_cnt - w0), 64'((beats - b0) * 4));
      end_dl();
   endtask

   task automatic copy_logo(input int base);
      for (int j = 0; j < 16; j++)
         img[base + 'h104 + j] = byte_at('h104 + j);
   endtask

   initial begin
      io.ioctl_wr   = 1'b0;
      io.ioctl_addr = '0;
      io.ioctl_dout = '0;
      io.dn_ack     = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("reset_outs", outs(), 64'd0);
      @(posedge clk_sys); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;

      // Good header; a beat pulsed during wait carries a bogus 0x147.
      img.delete();
      img['h147] = 8'h19;
      img['h148] = 8'h05;
      img['h149] = 8'h03;
      img['h14D] = hdr_chk();
      glitch_en = 1'b1;
      download('h200, 4'b0000);
      glitch_en = 1'b0;
      check("tp_mbc", 64'(mbc_type), 64'h19);
      check("tp_valid", 64'(hdr_valid), 64'd1);

      // Same image, checksum byte flipped.
      img['h14D] = img['h14D] ^ 8'hFF;
      download('h200, 4'b0000);
      check("tp_bad_valid", 64'(hdr_valid), 64'd0);

      // Download ends while still inside the header.
      download('h140, 4'b0000);

      // 1 MiB image: logo copied into banks 0x40000 and 0xC0000 only.
      img['h14D] = hdr_chk();
      copy_logo('h40000);
      copy_logo('hC0000);
      download('h200, 4'b0111);
      check("tp_probe", 64'(probe_match), 64'b0101);

      // Reset in STREAM, then a fresh image with 0x147=0x01.
      start_dl();
      stream(0, 'h200);
      stream('h40104, 'h40114);
      reset_n = 1'b0;
      @(negedge clk_sys);
      check("reset_mid", outs(), 64'd0);
      cart_download = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      img.delete();
      img['h147] = 8'h01;
      img['h14D] = hdr_chk();
      download('h200, 4'b0000);
      check("tp_new_mbc", 64'(mbc_type), 64'h01);
      check("tp_new_probe", 64'(probe_match), 64'd0);

`ifdef CART_SACHEN_DETECT_EN
      img.delete();
      img['h101] = 8'h00;
      img['h140] = 8'hC3;
      img['h143] = 8'h80;
      img['h147] = 8'h19;
      img['h14D] = hdr_chk() ^ 8'h01;
      download('h200, 4'b0000);
      check("tp_sachen", 64'(sachen), 64'd1);
      check("tp_sachen_mbc", 64'(mbc_type), 64'd0);
      check("tp_sachen_cgb", 64'(cgb_flag), 64'd1);
      check("tp_sachen_valid", 64'(hdr_valid), 64'd1);
`endif

      repeat (4) @(posedge clk_sys);
      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cart_header_probe.md
Name: cart_header_probe

Overview:
- Next-generation cartridge download front end; sits between the ioctl download stream and the mapper/cart RAM logic.
- Parses the GB header (0x100–0x14F), verifies the header checksum, and paces the stream with a wait/ack handshake toward the SDRAM writer.
- Runs NPROBE parallel multicart logo probes at configurable strides, generalising the single fixed-offset logo compare.

Parameters:
- DW, 16, ioctl data width; 8 or 16. With 16, byte at even address = dout[7:0] and byte at address+1 = dout[15:8].
- ADDR_W, 25, ioctl byte-address width.
- NPROBE, 4, number of logo-probe channels.
- PROBE_STRIDE, 'h40000, probe channel k inspects bank base (k+1)*PROBE_STRIDE.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cart_download  in  1  download window active
- ioctl_wr  in  1  one-cycle write strobe
- ioctl_addr  in  ADDR_W  byte address of the beat
- ioctl_dout  in  DW  beat data
- dn_ack  in  1  downstream writer accepted the beat
- ioctl_wait  out  1  stall the ioctl source
- mbc_type  out  8  header byte 0x147
- rom_size  out  8  header byte 0x148
- ram_size  out  8  header byte 0x149
- cgb_flag  out  1  bit 7 of byte 0x143
- sgb_flag  out  8  header byte 0x146
- old_licensee  out  8  header byte 0x14B
- hdr_done  out  1  level; parse finished for this download
- hdr_valid  out  1  level; checksum matched
- probe_match  out  NPROBE  per-channel logo match
- sachen  out  1  Sachen cart detected (optional feature)

Behaviour:
- Reset: all outputs and registers 0. State IDLE. Logo store cleared.
- FSM states: IDLE, HEADER, STREAM, DONE.
  - Rising edge of cart_download, from any state: clear every header output, hdr_*, probe_match, checksum accumulator and all probe flags; go to HEADER.
  - HEADER → STREAM after the beat containing byte 0x14F is accepted.
  - Falling edge of cart_download in HEADER or STREAM → DONE. hdr_done=1 one cycle later. Outputs then hold until the next rising edge or reset.
  - If the download ends in HEADER: hdr_valid=0 and probe_match=0.
- Handshake:
  - Accepted beat = ioctl_wr while ioctl_wait=0.
  - ioctl_wait rises the cycle after an accepted beat and falls the cycle after dn_ack.
  - ioctl_wr while ioctl_wait=1 is ignored (not parsed).
  - dn_ack while ioctl_wait=0 is ignored.
  - dn_ack coincident with a new ioctl_wr: wait falls, and the new beat is accepted next cycle only if it is still presented.
- Header capture: only beats whose address bits [ADDR_W-1:12] are 0 are parsed. Every byte lane in the beat is decoded independently.
- Checksum:
  - Accumulator x is 8 bits, starts at 0.
  - For each byte b at 0x134..0x14C: x = x - b - 1, modulo 256.
  - When byte 0x14D arrives, register its compare against x. If 0x14C and 0x14D share a beat, use the x value that includes 0x14C.
  - hdr_valid is set one cycle after the 0x14D beat.
- Logo store: bytes 0x104..0x113 (16 bytes) from bank 0 go into a 16x8 store.
- Probe channel k:
  - Window = base (k+1)*PROBE_STRIDE + 0x104..0x113.
  - Each byte is compared against logo[offset]. A 16-bit seen mask and a 16-bit equal mask are kept per channel.
  - probe_match[k] = all seen & all equal, evaluated at entry to DONE.
  - Channels whose base is at or above the image end never match.
- Channels are independent. One beat can hit at most one channel, because PROBE_STRIDE ≥ 'h1000.
- Address wrap beyond 2^ADDR_W is undefined.
- Reset mid-download: immediate return to IDLE with all outputs 0. No partial state survives.

Optional Feature:
- CART_SACHEN_DETECT_EN defined:
  - t1 = byte 0x101 != 0xC3.
  - t2 = byte 0x140 == 0xC3.
  - On byte 0x150 with t1&t2: sachen=1, and mbc_type, rom_size, ram_size, sgb_flag and old_licensee are forced to 0. cgb_flag is retaken from bit 7 of byte 0x143 as already captured.
  - In this case hdr_valid is forced to 1.
- Undefined: sachen tied 0, no 0x150 handling, and the FSM leaves HEADER at 0x14F as above.

Test Plan:
- 32 KiB image with 0x147=0x19, 0x148=0x05, 0x149=0x03, correct 0x14D, dn_ack 3 cycles after each beat → mbc_type=0x19, rom_size=5, ram_size=3, hdr_valid=1, hdr_done=1 one cycle after cart_download falls; ioctl_wait high exactly 4 cycles per beat.
- Same image with 0x14D flipped → hdr_valid=0, hdr_done=1, other fields unchanged.
- 1 MiB image with the bank-0 logo copied at 0x40000 and 0xC0000 only, NPROBE=4 → probe_match=4'b0101.
- ioctl_wr pulsed while ioctl_wait=1 with data differing at 0x147 → mbc_type keeps the first accepted value.
- reset_n low during STREAM, then a new download of an image with 0x147=0x01 → all outputs 0 during reset; afterwards mbc_type=0x01 and probe_match reflects only the new image.
- With CART_SACHEN_DETECT_EN, byte 0x101=0x00, byte 0x140=0xC3, and byte 0x143=0x80 in the header → sachen=1, mbc_type=0, cgb_flag=1, hdr_valid=1.
